// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - event-counting 4-phase request/acknowledge transmitter
module pulse_handshake_tx #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_async,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] P_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_pending;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic w_ack_s;
    logic w_launch;
    logic w_drop;
    logic w_inc;
    logic w_dec;

    // Only the last synchronizer stage is ever looked at.
    assign w_ack_s = r_sync[SYNC_STAGES-1];

    // A stale ack (still high while idle) blocks a new launch until it falls.
    assign w_launch = (r_state == IDLE) && !w_ack_s && ((r_pending != '0) || pulse_in);

    // An event is lost only when the counter is full and nothing drains it this cycle.
    assign w_drop = pulse_in && (r_pending == P_MAX) && !w_launch;
    assign w_inc  = pulse_in && !w_drop;

    // A launch with an empty counter is fed by the same-cycle pulse, so inc and dec cancel.
    assign w_dec  = w_launch;

    assign req_out  = r_req;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign done     = r_done;
    assign overflow = r_overflow;

    // Ack synchronizer shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_async};
        end
    end

    // Pending-event counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_inc && !w_dec) begin
                r_pending <= r_pending + 1'b1;
            end else if (!w_inc && w_dec) begin
                r_pending <= r_pending - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Handshake FSM with registered req/busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_state <= REL;
                        r_req   <= 1'b0;
                    end
                end
                REL: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_handshake_tx.md
PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 Parameter CNT_W, default 4: width of the pending-event counter; maximum pending count is 2^CNT_W-1.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of flops in the ack input synchronizer.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pulse_in  input  1  single-cycle event to transfer; every high cycle counts as one event.
REQ-006 ack_async  input  1  acknowledge from the receiving domain; asynchronous to clk.
REQ-007 req_out  output  1  4-phase request level to the receiving domain; driven directly from a flop.
REQ-008 busy  output  1  high while a handshake is in progress (FSM not IDLE).
REQ-009 pending  output  CNT_W  events accepted but not yet launched.
REQ-010 done  output  1  one-cycle pulse when a handshake completes.
REQ-011 overflow  output  1  sticky flag; set when an event is dropped.

Function
REQ-012 ack_async shall pass through SYNC_STAGES flops to form ack_s; only ack_s is used by any other logic.
REQ-013 FSM states: IDLE (req_out=0), REQ (req_out=1), REL (req_out=0).
REQ-014 launch = IDLE and (pending!=0 or pulse_in); on launch the FSM moves IDLE->REQ, and req_out is high in the next cycle.
REQ-015 REQ->REL when ack_s=1; req_out drops in the cycle after ack_s is sampled high.
REQ-016 REL->IDLE when ack_s=0; done is high for exactly that one transition cycle (the first IDLE cycle).
REQ-017 In IDLE with ack_s still 1 (a stale ack), no launch shall occur until ack_s=0.
REQ-018 pending update: +1 on accepted pulse_in, -1 on launch; when both occur in the same cycle, pending is unchanged.
REQ-019 A launch with pending=0 shall consume the same-cycle pulse_in directly; pending stays 0.
REQ-020 Drop condition: pulse_in=1, pending=2^CNT_W-1 and no launch; the event is discarded, pending holds, and overflow is set.
REQ-021 overflow shall clear only on rst.
REQ-022 pending shall never wrap at either end: no increment past the maximum, no decrement below 0.
REQ-023 pulse_in during REQ or REL shall be queued in pending, subject to REQ-020.
REQ-024 Consecutive handshakes: after done, a launch may occur in the same IDLE cycle if pending!=0 and ack_s=0; req_out then rises in the next cycle.
REQ-025 Minimum handshake length, from launch to done, is 2*SYNC_STAGES+3 cycles with a zero-delay ack loop.

Reset
REQ-026 While rst=1, the following shall hold at the next edge: FSM=IDLE, req_out=0, busy=0, done=0, pending=0, overflow=0, and all synchronizer flops=0.
REQ-027 Reset asserted mid-handshake shall abandon the transfer and flush pending events; an ack still high after reset is handled by REQ-017.
REQ-028 pulse_in during a rst=1 cycle shall be ignored.

Verification
REQ-029 Single pulse_in, ack loopback delayed 3 cycles -> exactly one req_out rise and one done pulse; pending stays 0; overflow=0.
REQ-030 Three back-to-back pulse_in cycles in IDLE -> pending reads 1 then 2; exactly 3 handshakes and 3 done pulses occur; pending ends at 0.
REQ-031 CNT_W=2, ack held low, 5 pulses -> first pulse launches, pending saturates at 3, fifth pulse dropped, overflow=1; after ack is released, 4 handshakes total.
REQ-032 pulse_in coincident with done while pending=1 -> launch occurs and pending remains 1 (simultaneous +1/-1).
REQ-033 rst asserted while in REQ with pending=2 -> next cycle req_out=0, pending=0, busy=0; with ack_async still 1, no launch occurs until ack_s falls.
REQ-034 ack_async held high from reset release, then one pulse_in -> pending=1 and req_out stays 0 until ack_s=0, then launch.
